// File: rtl/x_pll_seq_if.sv
// Bus between the PLL lock sequencer and its surroundings.
// The statistics ports exist only when X_PLL_SEQ_STATS_EN is defined.
interface x_pll_seq_if;
  logic       i_en;
  logic       i_pll_lock;
  logic       o_pll_nrst;
  logic       o_sys_rst;
  logic       o_ready;
  logic       o_fail;
  logic [2:0] o_state;
`ifdef X_PLL_SEQ_STATS_EN
  logic [7:0] o_loss_cnt;
  logic [7:0] o_retry_tot;

  modport master (input i_en, i_pll_lock,
                  output o_pll_nrst, o_sys_rst, o_ready, o_fail, o_state, o_loss_cnt, o_retry_tot);
  modport slave  (output i_en, i_pll_lock,
                  input o_pll_nrst, o_sys_rst, o_ready, o_fail, o_state, o_loss_cnt, o_retry_tot);
`else
  modport master (input i_en, i_pll_lock,
                  output o_pll_nrst, o_sys_rst, o_ready, o_fail, o_state);
  modport slave  (output i_en, i_pll_lock,
                  input o_pll_nrst, o_sys_rst, o_ready, o_fail, o_state);
`endif
endinterface

// File: rtl/x_pll_seq.sv
// iCE40 PLL power-up/lock sequencer: RESETB pulse, lock wait with retry, lock qualification.
// Optional lock-loss / timeout statistics counters enabled by X_PLL_SEQ_STATS_EN.
module x_pll_seq #(
  parameter int P_RST_CYCLES    = 16,
  parameter int P_LOCK_TIMEOUT  = 1200,
  parameter int P_STABLE_CYCLES = 64,
  parameter int P_MAX_RETRY     = 3,
  parameter int P_CNT_W         = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  x_pll_seq_if.master    pll_io
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLL_RST   = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_STABLE    = 3'd3,
    S_RUN       = 3'd4,
    S_FAIL      = 3'd5
  } state_e;

  localparam logic [P_CNT_W-1:0] RST_LAST = P_CNT_W'(P_RST_CYCLES - 1);
  localparam logic [P_CNT_W-1:0] TMO_LAST = P_CNT_W'(P_LOCK_TIMEOUT - 1);
  localparam logic [P_CNT_W-1:0] STB_LAST = P_CNT_W'(P_STABLE_CYCLES - 1);
  localparam logic [3:0]         RETRY_MAX = 4'(P_MAX_RETRY);

  state_e             state_q, state_d;
  logic [P_CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]         retry_q, retry_d;
  logic               lock_meta_q, lock_s_q;
  logic               loss_evt, tmo_evt;

  // LOCK comes straight from the PLL, unrelated to the reference clock
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_io.i_pll_lock;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    loss_evt = 1'b0;
    tmo_evt  = 1'b0;
    if (!pll_io.i_en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
          retry_d = '0;
        end
        S_PLL_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s_q) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TMO_LAST) begin
            tmo_evt = 1'b1;
            retry_d = retry_q + 4'd1;
            cnt_d   = '0;
            state_d = (retry_q + 4'd1 == RETRY_MAX) ? S_FAIL : S_PLL_RST;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_STABLE: begin
          // A dropout restarts the lock window without burning a retry
          if (!lock_s_q) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STB_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          if (!lock_s_q) begin
            loss_evt = 1'b1;
            state_d  = S_PLL_RST;
            cnt_d    = '0;
            retry_d  = '0;
          end
        end
        S_FAIL: state_d = S_FAIL;
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          retry_d = '0;
        end
      endcase
    end
  end

  assign pll_io.o_pll_nrst = (state_q == S_WAIT_LOCK) || (state_q == S_STABLE) || (state_q == S_RUN);
  assign pll_io.o_sys_rst  = (state_q != S_RUN);
  assign pll_io.o_ready    = (state_q == S_RUN);
  assign pll_io.o_fail     = (state_q == S_FAIL);
  assign pll_io.o_state    = state_q;

`ifdef X_PLL_SEQ_STATS_EN
  logic [7:0] loss_cnt_q, retry_tot_q;

  // Only i_rst clears the statistics so they survive an enable cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      loss_cnt_q  <= '0;
      retry_tot_q <= '0;
    end else begin
      if (loss_evt && loss_cnt_q != 8'hFF)  loss_cnt_q  <= loss_cnt_q + 8'd1;
      if (tmo_evt && retry_tot_q != 8'hFF)  retry_tot_q <= retry_tot_q + 8'd1;
    end
  end

  assign pll_io.o_loss_cnt  = loss_cnt_q;
  assign pll_io.o_retry_tot = retry_tot_q;
`else
  logic unused_evt;
  assign unused_evt = loss_evt ^ tmo_evt;
`endif

endmodule

// File: tb/tb_x_pll_seq.sv
// Directed bench for x_pll_seq with small timing parameters; edge counts are hand-derived.
module tb_x_pll_seq;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  x_pll_seq_if bus ();

  x_pll_seq #(
    .P_RST_CYCLES(4), .P_LOCK_TIMEOUT(20), .P_STABLE_CYCLES(8), .P_MAX_RETRY(2), .P_CNT_W(16)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .pll_io(bus.master)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    bit ok;
    rst = 1'b1; bus.i_en = 1'b0; bus.i_pll_lock = 1'b1;
    tick(); tick();
    chk("rst_state", 32'(bus.o_state), 0);
    chk("rst_nrst",  32'(bus.o_pll_nrst), 0);
    chk("rst_sysrst", 32'(bus.o_sys_rst), 1);
    chk("rst_ready", 32'(bus.o_ready), 0);
    chk("rst_fail",  32'(bus.o_fail), 0);
    rst = 1'b0;
    tick(); tick(); tick();
    chk("idle_hold", 32'(bus.o_state), 0);

    // 1: clean lock, RUN after the 14th edge counting the enable edge
    bus.i_en = 1'b1;
    tick();
    chk("t1_e0_state", 32'(bus.o_state), 1);
    chk("t1_e0_nrst", 32'(bus.o_pll_nrst), 0);
    repeat (3) tick();
    chk("t1_e3_state", 32'(bus.o_state), 1);
    tick();
    chk("t1_e4_state", 32'(bus.o_state), 2);
    chk("t1_e4_nrst", 32'(bus.o_pll_nrst), 1);
    tick();
    chk("t1_e5_state", 32'(bus.o_state), 3);
    repeat (7) tick();
    chk("t1_e12_ready", 32'(bus.o_ready), 0);
    tick();
    chk("t1_e13_ready", 32'(bus.o_ready), 1);
    chk("t1_e13_sysrst", 32'(bus.o_sys_rst), 0);
    chk("t1_e13_state", 32'(bus.o_state), 4);

    // 4: lock loss in RUN, then recovery
    bus.i_pll_lock = 1'b0;
    tick(); tick();
    chk("t4_sync_ready", 32'(bus.o_ready), 1);
    tick();
    chk("t4_loss_state", 32'(bus.o_state), 1);
    chk("t4_loss_ready", 32'(bus.o_ready), 0);
    chk("t4_loss_sysrst", 32'(bus.o_sys_rst), 1);
    chk("t4_loss_nrst", 32'(bus.o_pll_nrst), 0);
    bus.i_pll_lock = 1'b1;
    repeat (12) tick();
    chk("t4_e12_ready", 32'(bus.o_ready), 0);
    tick();
    chk("t4_e13_ready", 32'(bus.o_ready), 1);
`ifdef X_PLL_SEQ_STATS_EN
    chk("t4_loss_cnt", 32'(bus.o_loss_cnt), 1);
`endif

    // 5: sync reset mid-RUN, then disable mid-WAIT_LOCK
    rst = 1'b1;
    tick();
    chk("t5_rst_state", 32'(bus.o_state), 0);
    chk("t5_rst_nrst", 32'(bus.o_pll_nrst), 0);
    chk("t5_rst_sysrst", 32'(bus.o_sys_rst), 1);
    chk("t5_rst_ready", 32'(bus.o_ready), 0);
    rst = 1'b0; bus.i_pll_lock = 1'b0;
    tick();
    chk("t5_e0_state", 32'(bus.o_state), 1);
    repeat (4) tick();
    chk("t5_e4_state", 32'(bus.o_state), 2);
    repeat (2) tick();
    bus.i_en = 1'b0;
    tick();
    chk("t5_dis_state", 32'(bus.o_state), 0);
    chk("t5_dis_nrst", 32'(bus.o_pll_nrst), 0);

    // 3: one-cycle lock dropout seen at STABLE cnt=5
    bus.i_pll_lock = 1'b1;
    tick(); tick(); tick();
    bus.i_en = 1'b1;
    tick();
    repeat (8) tick();
    bus.i_pll_lock = 1'b0;
    tick();
    bus.i_pll_lock = 1'b1;
    tick();
    chk("t3_e10_state", 32'(bus.o_state), 3);
    tick();
    chk("t3_e11_state", 32'(bus.o_state), 2);
    chk("t3_e11_nrst", 32'(bus.o_pll_nrst), 1);
    tick();
    chk("t3_e12_state", 32'(bus.o_state), 3);
    repeat (7) tick();
    chk("t3_e19_ready", 32'(bus.o_ready), 0);
    tick();
    chk("t3_e20_ready", 32'(bus.o_ready), 1);

    // 2: never locks -> two attempts then FAIL
    rst = 1'b1; bus.i_en = 1'b0; bus.i_pll_lock = 1'b0;
    tick();
    rst = 1'b0; bus.i_en = 1'b1;
    tick();
    repeat (23) tick();
    chk("t2_e23_state", 32'(bus.o_state), 2);
    tick();
    chk("t2_e24_state", 32'(bus.o_state), 1);
`ifdef X_PLL_SEQ_STATS_EN
    chk("t2_tot1", 32'(bus.o_retry_tot), 1);
`endif
    repeat (23) tick();
    chk("t2_e47_state", 32'(bus.o_state), 2);
    tick();
    chk("t2_e48_state", 32'(bus.o_state), 5);
    chk("t2_e48_fail", 32'(bus.o_fail), 1);
    chk("t2_e48_nrst", 32'(bus.o_pll_nrst), 0);
    repeat (5) tick();
    chk("t2_sticky", 32'(bus.o_state), 5);
`ifdef X_PLL_SEQ_STATS_EN
    chk("t2_tot2", 32'(bus.o_retry_tot), 2);
`endif
    bus.i_en = 1'b0;
    tick();
    chk("t2_dis_state", 32'(bus.o_state), 0);
    chk("t2_dis_fail", 32'(bus.o_fail), 0);

`ifdef X_PLL_SEQ_STATS_EN
    // 6: lock-loss counter saturates
    rst = 1'b1; bus.i_pll_lock = 1'b1;
    tick();
    rst = 1'b0; bus.i_en = 1'b1;
    for (int k = 0; k < 301; k++) begin
      ok = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin
        tick();
        ok = bus.o_ready;
      end
      if (!ok) begin
        chk("t6_timeout", 32'(ok), 1);
        break;
      end
      if (k == 300) break;
      bus.i_pll_lock = 1'b0;
      repeat (3) tick();
      bus.i_pll_lock = 1'b1;
    end
    chk("t6_loss_sat", 32'(bus.o_loss_cnt), 255);
    bus.i_en = 1'b0;
    tick();
    chk("t6_keep_on_dis", 32'(bus.o_loss_cnt), 255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
